// File: rtl/seg_display_sequencer_if.sv
// seg_display_sequencer_if: load/capture inputs and display outputs of the sequencer.
interface seg_display_sequencer_if;
  logic       load;
  logic [6:0] seg1, seg2, seg3, seg4;
  logic       isNegative1, isNegative2, isNegative3, isNegative4;
  logic [6:0] segments;
  logic       dp;
  logic [1:0] element_idx;
  logic       busy;
  logic       done;
  modport master (
    output load, seg1, seg2, seg3, seg4,
    output isNegative1, isNegative2, isNegative3, isNegative4,
    input  segments, dp, element_idx, busy, done
  );
  modport slave (
    input  load, seg1, seg2, seg3, seg4,
    input  isNegative1, isNegative2, isNegative3, isNegative4,
    output segments, dp, element_idx, busy, done
  );
endinterface

// File: rtl/seg_display_sequencer.sv
// seg_display_sequencer: shows four captured 7-segment elements in turn on one display,
// each for DWELL_CYCLES clocks followed by BLANK_CYCLES of blank, once or looping.
module seg_display_sequencer #(
  parameter int unsigned DWELL_CYCLES = 12000000,
  parameter int unsigned BLANK_CYCLES = 1200000,
  parameter int unsigned REPEAT       = 0
) (
  input  logic clk,
  input  logic rst_n,
  seg_display_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;
  localparam logic [23:0] DWELL_LAST = 24'(DWELL_CYCLES - 1);
  localparam logic [23:0] BLANK_LAST = 24'(BLANK_CYCLES == 0 ? 0 : BLANK_CYCLES - 1);
  localparam bit HAS_BLANK = BLANK_CYCLES != 0;
  localparam bit LOOP = REPEAT != 0;
  state_t          state, state_n;
  logic [1:0]      idx, idx_n;
  logic [23:0]     cnt, cnt_n;
  logic [3:0][6:0] cap_seg, cap_seg_n;
  logic [3:0]      cap_neg, cap_neg_n;
  logic            done_n, advance;
  always_comb begin
    cap_seg_n = bus.load ? {bus.seg4, bus.seg3, bus.seg2, bus.seg1} : cap_seg;
    cap_neg_n = bus.load ? {bus.isNegative4, bus.isNegative3, bus.isNegative2, bus.isNegative1} : cap_neg;
    state_n   = state;
    idx_n     = idx;
    cnt_n     = cnt + 24'd1;
    done_n    = 1'b0;
    advance   = 1'b0;
    if (bus.load) begin
      state_n = SHOW;
      idx_n   = 2'd0;
      cnt_n   = '0;
    end else begin
      case (state)
        SHOW: begin
          if (cnt == DWELL_LAST) begin
            if (HAS_BLANK) begin
              state_n = BLANK;
              cnt_n   = '0;
            end else begin
              advance = 1'b1;
            end
          end
        end
        BLANK:   advance = cnt == BLANK_LAST;
        default: cnt_n = '0;
      endcase
    end
    // idx + 1 wraps 3 -> 0, which is exactly the looping behaviour
    if (advance) begin
      cnt_n = '0;
      if (idx != 2'd3 || LOOP) begin
        state_n = SHOW;
        idx_n   = idx + 2'd1;
      end else begin
        state_n = IDLE;
        idx_n   = 2'd0;
        done_n  = 1'b1;
      end
    end
  end
  // outputs are registered from next-state values so they track state with no lag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      idx             <= '0;
      cnt             <= '0;
      cap_seg         <= '0;
      cap_neg         <= '0;
      bus.segments    <= '0;
      bus.dp          <= 1'b0;
      bus.element_idx <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
    end else begin
      state           <= state_n;
      idx             <= idx_n;
      cnt             <= cnt_n;
      cap_seg         <= cap_seg_n;
      cap_neg         <= cap_neg_n;
      bus.segments    <= state_n == SHOW ? cap_seg_n[idx_n] : 7'd0;
      bus.dp          <= state_n == SHOW && cap_neg_n[idx_n];
      bus.element_idx <= idx_n;
      bus.busy        <= state_n != IDLE;
      bus.done        <= done_n;
    end
  end
endmodule
